// File: rtl/nios2_ls_ocimem_access_arbiter.sv
// Purpose : shares the single-port OCI debug RAM between JTAG strobes and the Avalon debug slave
// Latency : Avalon write 2 cycles, read 3 cycles; JTAG write hits RAM 2 cycles after strobe, MonDReg 4
// Backpr. : Avalon stalled with av_waitrequest; JTAG strobes cannot stall, 1-entry buffer, drops flagged in jtag_ovf
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   jdo, take_action_ocimem_a/b,      JTAG data and strobes (load address / write / read)
//   take_no_action_ocimem_a
//   av_address/read/write/writedata/  Avalon debug slave; av_readdata valid when read && !waitrequest
//   byteenable/readdata/waitrequest
//   ram_addr/wren/byteen/wrdata,      registered RAM command; ram_rddata returns 1 cycle after ram_addr
//   ram_rddata
//   MonDReg, jtag_busy, jtag_ovf      JTAG read result, JTAG activity, sticky dropped-op flag
module nios2_ls_ocimem_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wrdata,
    input  logic [DATA_W-1:0] ram_rddata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_ovf
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] J_WR       = 3'd1;
    localparam logic [2:0] J_RD       = 3'd2;
    localparam logic [2:0] J_RD_WAIT  = 3'd3;
    localparam logic [2:0] AV_WR      = 3'd4;
    localparam logic [2:0] AV_RD      = 3'd5;
    localparam logic [2:0] AV_RD_WAIT = 3'd6;

    logic [2:0]        state;
    logic              last_grant_av;   // 1: Avalon was served most recently
    logic [ADDR_W-1:0] jaddr;
    logic              jpend;
    logic              jop_wr;
    logic [DATA_W-1:0] jdata;

    logic av_req;
    logic j_state;
    logic j_done;
    logic strobe_op;
    logic accept;
    logic unused_jdo_bits;

    // jdo bits outside the address and data fields carry nothing for this block
    assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

    assign av_req  = av_read | av_write;
    assign j_state = (state == J_WR) | (state == J_RD) | (state == J_RD_WAIT);
    assign j_done  = (state == J_WR) | (state == J_RD_WAIT);

    // Address load outranks write, which outranks read; only the top strobe acts.
    assign strobe_op = ~take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a);
    assign accept    = strobe_op & ~jpend & ~j_state;

    assign jtag_busy      = jpend | j_state;
    assign av_waitrequest = av_req & ~((state == AV_WR) | (state == AV_RD_WAIT));
    assign av_readdata    = (state == AV_RD_WAIT) ? ram_rddata : '0;

    // JTAG side: address register, 1-entry pending op, read result, overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jaddr    <= '0;
            jpend    <= 1'b0;
            jop_wr   <= 1'b0;
            jdata    <= '0;
            MonDReg  <= '0;
            jtag_ovf <= 1'b0;
        end else begin
            // A fresh address load wins over the post-op increment in the same cycle.
            if (take_action_ocimem_a) begin
                jaddr <= jdo[ADDR_W+25:26];
            end else if (j_done) begin
                jaddr <= jaddr + ADDR_W'(1);
            end

            if (accept) begin
                jpend  <= 1'b1;
                jop_wr <= take_action_ocimem_b;
                jdata  <= jdo[34:3];
            end else if (j_done) begin
                jpend <= 1'b0;
            end

            if (strobe_op && !accept) begin
                jtag_ovf <= 1'b1;
            end

            if (state == J_RD_WAIT) begin
                MonDReg <= ram_rddata;
            end
        end
    end

    // Arbiter FSM; RAM command registers are loaded on the grant edge so the
    // command is presented to the RAM throughout the following state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_grant_av <= 1'b0;   // first tie after reset goes to Avalon
            ram_addr      <= '0;
            ram_wren      <= 1'b0;
            ram_byteen    <= '0;
            ram_wrdata    <= '0;
        end else begin
            ram_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (jpend && (!av_req || last_grant_av)) begin
                        last_grant_av <= 1'b0;
                        ram_addr      <= jaddr;
                        if (jop_wr) begin
                            state      <= J_WR;
                            ram_wren   <= 1'b1;
                            ram_byteen <= 4'hF;
                            ram_wrdata <= jdata;
                        end else begin
                            state <= J_RD;
                        end
                    end else if (av_req) begin
                        last_grant_av <= 1'b1;
                        ram_addr      <= av_address;
                        if (av_write) begin
                            state      <= AV_WR;
                            ram_wren   <= 1'b1;
                            ram_byteen <= av_byteenable;
                            ram_wrdata <= av_writedata;
                        end else begin
                            state <= AV_RD;
                        end
                    end
                end
                J_RD:    state <= J_RD_WAIT;
                AV_RD:   state <= AV_RD_WAIT;
                // J_WR, J_RD_WAIT, AV_WR, AV_RD_WAIT all finish in one cycle
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_ls_ocimem_access_arbiter.sv
module tb_nios2_ls_ocimem_access_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wrdata;
    logic [31:0] ram_rddata;
    logic [31:0] MonDReg;
    logic        jtag_busy, jtag_ovf;

    always #5 clk = ~clk;

    nios2_ls_ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
        .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata),
        .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_ovf(jtag_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Synchronous single-port RAM with byte enables, 1-cycle read latency
    logic [31:0] mem [256];
    logic        clear_mem;
    int          wr_count = 0;
    logic [3:0]  last_be;
    logic [7:0]  last_waddr;
    logic [31:0] last_wdata;

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
            wr_count   <= wr_count + 1;
            last_be    <= ram_byteen;
            last_waddr <= ram_addr;
            last_wdata <= ram_wrdata;
        end
        ram_rddata <= mem[ram_addr];
    end

    // Reference model: word array plus the JTAG auto-incrementing address
    logic [31:0] mem_m [256];
    logic [7:0]  jaddr_m;

    task automatic m_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_addr(input logic [7:0] a);
        logic [37:0] v;
        v = {6'($urandom()), $urandom()};
        v[33:26] = a;
        return v;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] v;
        v = {6'($urandom()), $urandom()};
        v[34:3] = d;
        return v;
    endfunction

    // kind: 0 load address, 1 write, 2 read; one-cycle pulse
    task automatic jstrobe(input int kind, input logic [37:0] v);
        jdo                     = v;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic jwait();
        int n;
        n = 0;
        while (jtag_busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("jtag_done_in_time", 32'(n < 20), 32'd1);
    endtask

    // Request already driven; counts cycles with waitrequest high, then releases.
    task automatic av_wait(output logic [31:0] rd, output int st);
        st = 0;
        #1;
        while (av_waitrequest === 1'b1 && st < 40) begin
            @(posedge clk);
            #2;
            st++;
        end
        chk("av_done_in_time", 32'(st < 40), 32'd1);
        rd = av_readdata;
        tick();
        av_read  = 1'b0;
        av_write = 1'b0;
    endtask

    task automatic av_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rd, output int st);
        av_address    = a;
        av_writedata  = d;
        av_byteenable = be;
        av_write      = wr;
        av_read       = ~wr;
        av_wait(rd, st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, d;
        logic [7:0]  a;
        logic [3:0]  be;
        int          st, wc, op;

        reset_n = 1'b0; clear_mem = 1'b1;
        jdo = '0; take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
        av_address = '0; av_read = 0; av_write = 0; av_writedata = '0; av_byteenable = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        jaddr_m = 8'h00;
        tick(); tick();

        // Reset state
        chk("rst_waitreq_idle", av_waitrequest, 0);
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_mondreg", MonDReg, 0);
        chk("rst_busy", jtag_busy, 0);
        chk("rst_ovf", jtag_ovf, 0);
        chk("rst_readdata", av_readdata, 0);
        av_read = 1'b1; #1;
        chk("rst_waitreq_req", av_waitrequest, 1);
        av_read = 1'b0; #1;
        reset_n = 1'b1; clear_mem = 1'b0;
        tick();

        // 1: Avalon write then read back
        av_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, st); m_wr(8'h10, 32'hDEADBEEF, 4'hF);
        chk("t1_wr_stalls", st, 1);
        av_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, st);
        chk("t1_rd_stalls", st, 2);
        chk("t1_rd_data", rd, 32'hDEADBEEF);

        // 5: single-byte write on word 0
        av_xfer(1'b1, 8'h00, 32'hAABBCCDD, 4'b0010, rd, st); m_wr(8'h00, 32'hAABBCCDD, 4'b0010);
        chk("t5_byteen", last_be, 4'b0010);
        chk("t5_waddr", last_waddr, 8'h00);
        av_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd, st);
        chk("t5_merged_word", rd, 32'h0000CC00);

        // 2: address load, write at top address, wrap, read next word
        jstrobe(0, jdo_addr(8'hFF)); jaddr_m = 8'hFF;
        jstrobe(1, jdo_data(32'h12345678));
        tick();
        chk("t2_wren", ram_wren, 1);
        chk("t2_addr", ram_addr, 8'hFF);
        chk("t2_byteen", ram_byteen, 4'hF);
        chk("t2_wrdata", ram_wrdata, 32'h12345678);
        tick();
        m_wr(jaddr_m, 32'h12345678, 4'hF); jaddr_m++;
        chk("t2_busy_clear", jtag_busy, 0);
        chk("t2_ram_ff", mem[8'hFF], 32'h12345678);
        jstrobe(2, jdo_addr(8'h77));
        tick();
        chk("t2_busy_rd", jtag_busy, 1);
        tick(); tick();
        chk("t2_mondreg", MonDReg, mem_m[jaddr_m]);
        chk("t2_busy_rd_done", jtag_busy, 0);
        jaddr_m++;
        jstrobe(1, jdo_data(32'h0BADF00D)); jwait();
        chk("t2_incr_addr", last_waddr, jaddr_m);
        m_wr(jaddr_m, 32'h0BADF00D, 4'hF); jaddr_m++;

        // 3: contention; Avalon write first so Avalon is last served
        av_address = 8'h20; av_writedata = 32'h5555AAAA; av_byteenable = 4'hF; av_write = 1'b1;
        tick();
        chk("t3_avwr_no_wait", av_waitrequest, 0);
        jdo = jdo_data(32'hC0FFEE01); take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0; av_write = 1'b0; av_read = 1'b1;
        m_wr(8'h20, 32'h5555AAAA, 4'hF);
        av_wait(rd, st);
        chk("t3_jtag_first_stalls", st, 4);
        chk("t3_rd_data", rd, 32'h5555AAAA);
        chk("t3_jtag_landed", mem[jaddr_m], 32'hC0FFEE01);
        chk("t3_busy_after", jtag_busy, 0);
        m_wr(jaddr_m, 32'hC0FFEE01, 4'hF); jaddr_m++;
        jstrobe(1, jdo_data(32'h11112222)); jwait();
        m_wr(jaddr_m, 32'h11112222, 4'hF); jaddr_m++;
        // JTAG was last served; a tie now goes to Avalon
        jstrobe(1, jdo_data(32'h33334444));
        av_address = 8'h20; av_read = 1'b1;
        av_wait(rd, st);
        chk("t3_av_first_stalls", st, 2);
        chk("t3_jtag_waiting", jtag_busy, 1);
        jwait();
        chk("t3_jtag2_landed", mem[jaddr_m], 32'h33334444);
        m_wr(jaddr_m, 32'h33334444, 4'hF); jaddr_m++;

        // 4: back-to-back write strobes, second dropped
        chk("t4_ovf_before", jtag_ovf, 0);
        wc = wr_count;
        jstrobe(1, jdo_data(32'hFEED0001));
        jstrobe(1, jdo_data(32'hFEED0002));
        jwait();
        chk("t4_ovf", jtag_ovf, 1);
        chk("t4_one_write", wr_count - wc, 1);
        chk("t4_first_kept", mem[jaddr_m], 32'hFEED0001);
        m_wr(jaddr_m, 32'hFEED0001, 4'hF); jaddr_m++;
        // simultaneous load+write: only the address load acts
        jdo = jdo_addr(8'h40); take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        jaddr_m = 8'h40;
        chk("t4_prio_no_op", jtag_busy, 0);

        // 6: reset during J_RD
        jstrobe(2, jdo_addr(8'h00));
        tick();
        chk("t6_mondreg_before", MonDReg, 32'h0000CC00);
        chk("t6_addr_before", ram_addr, 8'h40);
        wc = wr_count;
        reset_n = 1'b0; #1;
        chk("t6_busy", jtag_busy, 0);
        chk("t6_mondreg", MonDReg, 0);
        chk("t6_wren", ram_wren, 0);
        chk("t6_addr", ram_addr, 0);
        chk("t6_ovf_cleared", jtag_ovf, 0);
        tick(); tick();
        reset_n = 1'b1; jaddr_m = 8'h00;
        tick(); tick(); tick(); tick();
        chk("t6_no_write", wr_count - wc, 0);
        chk("t6_busy_after", jtag_busy, 0);
        chk("t6_mondreg_after", MonDReg, 0);

        // Randomised serial traffic against the model
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4);
            a  = 8'($urandom_range(0, 7)) | ($urandom_range(0, 1) != 0 ? 8'hF8 : 8'h00);
            d  = $urandom();
            be = 4'($urandom_range(0, 15));
            case (op)
                0: begin
                    av_xfer(1'b1, a, d, be, rd, st); m_wr(a, d, be);
                    chk("rnd_av_wr_stalls", st, 1);
                end
                1: begin
                    av_xfer(1'b0, a, 32'h0, 4'hF, rd, st);
                    chk("rnd_av_rd_stalls", st, 2);
                    chk("rnd_av_rd_data", rd, mem_m[a]);
                end
                2: begin
                    jstrobe(0, jdo_addr(a)); jaddr_m = a;
                end
                3: begin
                    jstrobe(1, jdo_data(d)); jwait();
                    m_wr(jaddr_m, d, 4'hF); jaddr_m++;
                end
                default: begin
                    jstrobe(2, jdo_data(d)); jwait();
                    chk("rnd_jtag_rd", MonDReg, mem_m[jaddr_m]);
                    jaddr_m++;
                end
            endcase
        end
        chk("rnd_no_ovf", jtag_ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
